// File: rtl/nios2_mul_combine.sv
// Two-stage (A, W) combine of the multiplier cell's 16x16 partial products into
// the low 32-bit MUL result, with valid/destination tracking and a retire counter.
module nios2_mul_combine #(
  parameter int unsigned RESULT_W = 32,
  parameter int unsigned REGNUM_W = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [RESULT_W-1:0] M_mul_cell_p1,
  input  logic [RESULT_W-1:0] M_mul_cell_p2,
  input  logic [RESULT_W-1:0] M_mul_cell_p3,
  input  logic                M_mul_valid,
  input  logic [REGNUM_W-1:0] M_dst_regnum,
  input  logic                stage_en,
  input  logic                flush,
  output logic                A_mul_pending,
  output logic [REGNUM_W-1:0] A_dst_regnum,
  output logic [RESULT_W-1:0] W_mul_result,
  output logic                W_mul_valid,
  output logic [REGNUM_W-1:0] W_dst_regnum,
  output logic [31:0]         mul_retired_count
);

  localparam int unsigned HALF_W = RESULT_W / 2;

  logic [RESULT_W-1:0] a_p1_q, a_p1_d;
  logic [HALF_W-1:0]   a_cross_q, a_cross_d;
  logic [REGNUM_W-1:0] a_dst_q, a_dst_d;
  logic                a_valid_q, a_valid_d;
  logic [RESULT_W-1:0] w_result_q, w_result_d;
  logic [REGNUM_W-1:0] w_dst_q, w_dst_d;
  logic                w_valid_q, w_valid_d;
  logic [31:0]         count_q, count_d;

  // Only the low halves of p2/p3 land inside the 32-bit product.
  always_comb begin
    a_p1_d     = a_p1_q;
    a_cross_d  = a_cross_q;
    a_dst_d    = a_dst_q;
    a_valid_d  = a_valid_q;
    w_result_d = w_result_q;
    w_dst_d    = w_dst_q;
    w_valid_d  = w_valid_q;
    count_d    = count_q;
    if (stage_en) begin
      a_p1_d     = M_mul_cell_p1;
      a_cross_d  = M_mul_cell_p2[HALF_W-1:0] + M_mul_cell_p3[HALF_W-1:0];
      a_dst_d    = M_dst_regnum;
      a_valid_d  = M_mul_valid & ~flush;
      w_result_d = a_p1_q + {a_cross_q, {HALF_W{1'b0}}};
      w_dst_d    = a_dst_q;
      w_valid_d  = a_valid_q & ~flush;
      if (a_valid_q && !flush) begin
        count_d = count_q + 32'd1;
      end
    end else if (flush) begin
      // Stalled flush still kills the A-stage MUL; W is never cancelled.
      a_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_p1_q     <= '0;
      a_cross_q  <= '0;
      a_dst_q    <= '0;
      a_valid_q  <= 1'b0;
      w_result_q <= '0;
      w_dst_q    <= '0;
      w_valid_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      a_p1_q     <= a_p1_d;
      a_cross_q  <= a_cross_d;
      a_dst_q    <= a_dst_d;
      a_valid_q  <= a_valid_d;
      w_result_q <= w_result_d;
      w_dst_q    <= w_dst_d;
      w_valid_q  <= w_valid_d;
      count_q    <= count_d;
    end
  end

  assign A_mul_pending     = a_valid_q;
  assign A_dst_regnum      = a_dst_q;
  assign W_mul_result      = w_result_q;
  assign W_mul_valid       = w_valid_q;
  assign W_dst_regnum      = w_dst_q;
  assign mul_retired_count = count_q;

endmodule
